// File: rtl/board_logic_pkg.sv
// Shared definitions for the connect-N board engine: result codes and
// the move-processing state machine encoding.
package bl_pkg;
  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_WIN     = 2'b01;
  localparam logic [1:0] RES_DRAW    = 2'b10;
  localparam logic [1:0] RES_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DROP,
    ST_SCAN_V,
    ST_SCAN_H,
    ST_SCAN_D,
    ST_SCAN_A,
    ST_REPORT
  } state_t;
endpackage

// File: rtl/board_logic_if.sv
// Move-request / result / readback bundle between a game controller
// (master) and the board engine (slave).
interface board_logic_if #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) ();
  localparam int CW = $clog2(COLS);

  logic            go;
  logic [CW-1:0]   col;
  logic            player;
  logic            new_game;
  logic [CW-1:0]   rd_col;
  logic [ROWS-1:0] rd_onoff;
  logic [ROWS-1:0] rd_player;
  logic            busy;
  logic            done;
  logic [1:0]      logic_result;
  logic            game_over;

  modport master (
    output go, col, player, new_game, rd_col,
    input  rd_onoff, rd_player, busy, done, logic_result, game_over
  );

  modport slave (
    input  go, col, player, new_game, rd_col,
    output rd_onoff, rd_player, busy, done, logic_result, game_over
  );
endinterface

// File: rtl/board_logic_run_counter.sv
// Counts same-owner occupied cells stepping (dx,dy) away from (x,y),
// excluding the start cell, stopping at the first gap or board edge.
module run_counter #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4,
  parameter int CW      = $clog2(COLS),
  parameter int HW      = $clog2(ROWS + 1),
  parameter int CNW     = $clog2(WIN_LEN + 1)
) (
  input  logic [COLS*ROWS-1:0] occ,
  input  logic [COLS*ROWS-1:0] own,
  input  logic [CW-1:0]        x,
  input  logic [HW-1:0]        y,
  input  logic signed [1:0]    dx,
  input  logic signed [1:0]    dy,
  input  logic                 owner,
  output logic [CNW-1:0]       count
);
  localparam int IW = $clog2(COLS * ROWS);

  always_comb begin : walk
    int cx;
    int cy;
    logic alive;
    logic inb;
    logic [IW-1:0] idx;
    count = '0;
    alive = 1'b1;
    cx    = int'(x);
    cy    = int'(y);
    for (int k = 0; k < WIN_LEN; k++) begin
      cx  = cx + int'(dx);
      cy  = cy + int'(dy);
      inb = (cx >= 0) && (cx < COLS) && (cy >= 0) && (cy < ROWS);
      idx = inb ? IW'(cx * ROWS + cy) : '0;
      if (alive && inb && occ[idx] && (own[idx] == owner))
        count = count + CNW'(1);
      else
        alive = 1'b0;
    end
  end
endmodule

// File: rtl/board_logic.sv
// Board engine: validates a move, drops the piece, scans the four line
// directions through it one per cycle and reports none/win/draw/illegal.
module board_logic
  import bl_pkg::*;
#(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic          clk,
  input  logic          reset,
  board_logic_if.slave  bus
);
  localparam int CW  = $clog2(COLS);
  localparam int HW  = $clog2(ROWS + 1);
  localparam int MW  = $clog2(COLS * ROWS + 1);
  localparam int CNW = $clog2(WIN_LEN + 1);
  localparam logic [CW:0]   COLS_W  = (CW + 1)'(COLS);
  localparam logic [HW-1:0] ROWS_H  = HW'(ROWS);
  localparam logic [MW-1:0] CELLS_M = MW'(COLS * ROWS);
  localparam logic [CNW:0]  WIN_W   = (CNW + 1)'(WIN_LEN);

  state_t state_reg, state_next;

  logic [ROWS-1:0]      occ_col    [COLS];
  logic [ROWS-1:0]      own_col    [COLS];
  logic [HW-1:0]        height_col [COLS];
  logic [COLS*ROWS-1:0] occ_flat, own_flat;

  logic [CW-1:0] col_reg;
  logic [HW-1:0] row_reg;
  logic          owner_reg, win_reg, pend_reg, pend_next;
  logic [MW-1:0] moves_reg;
  logic          game_over_reg, done_reg, done_next;
  logic [1:0]    result_reg, result_next;

  logic          busy, do_clear, set_over, accept, legal, col_ok, rd_ok;
  logic          scan_step, step_win;
  logic [HW-1:0] sel_height;
  logic signed [1:0] dx, dy, ndx, ndy;
  logic [CNW-1:0] fwd_cnt, bwd_cnt;
  logic [CNW:0]   run_total;

  assign col_ok     = {1'b0, bus.col} < COLS_W;
  assign rd_ok      = {1'b0, bus.rd_col} < COLS_W;
  assign sel_height = col_ok ? height_col[bus.col] : '0;
  assign legal      = col_ok && (sel_height != ROWS_H) && !game_over_reg;
  assign accept     = (state_reg == ST_IDLE) && bus.go && !bus.new_game && legal;

  // Each column owns its storage; only the selected column writes during DROP.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic [ROWS-1:0] occ_reg, own_reg;
    logic [HW-1:0]   height_reg;
    logic            wr_en;

    assign wr_en = (state_reg == ST_DROP) && (col_reg == CW'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        occ_reg    <= '0;
        own_reg    <= '0;
        height_reg <= '0;
      end else if (do_clear) begin
        occ_reg    <= '0;
        own_reg    <= '0;
        height_reg <= '0;
      end else if (wr_en) begin
        occ_reg[row_reg] <= 1'b1;
        own_reg[row_reg] <= owner_reg;
        height_reg       <= height_reg + HW'(1);
      end
    end

    assign occ_col[gi]                = occ_reg;
    assign own_col[gi]                = own_reg;
    assign height_col[gi]             = height_reg;
    assign occ_flat[gi*ROWS +: ROWS]  = occ_reg;
    assign own_flat[gi*ROWS +: ROWS]  = own_reg;
  end

  always_comb begin
    dx = 2'sb00;
    dy = 2'sb00;
    case (state_reg)
      ST_SCAN_V: dy = 2'sb01;
      ST_SCAN_H: dx = 2'sb01;
      ST_SCAN_D: begin dx = 2'sb01; dy = 2'sb01; end
      ST_SCAN_A: begin dx = 2'sb01; dy = 2'sb11; end
      default: ;
    endcase
  end

  assign ndx = -dx;
  assign ndy = -dy;

  run_counter #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN)) u_fwd (
    .occ(occ_flat), .own(own_flat), .x(col_reg), .y(row_reg),
    .dx(dx), .dy(dy), .owner(owner_reg), .count(fwd_cnt)
  );

  run_counter #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN)) u_bwd (
    .occ(occ_flat), .own(own_flat), .x(col_reg), .y(row_reg),
    .dx(ndx), .dy(ndy), .owner(owner_reg), .count(bwd_cnt)
  );

  // Line length through the placed piece = both arms plus the piece itself.
  assign run_total = (CNW + 1)'(fwd_cnt) + (CNW + 1)'(bwd_cnt) + (CNW + 1)'(1);
  assign step_win  = run_total >= WIN_W;
  assign scan_step = (state_reg == ST_SCAN_V) || (state_reg == ST_SCAN_H) ||
                     (state_reg == ST_SCAN_D) || (state_reg == ST_SCAN_A);

  always_comb begin
    state_next  = state_reg;
    done_next   = 1'b0;
    result_next = result_reg;
    pend_next   = pend_reg;
    do_clear    = 1'b0;
    set_over    = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.new_game) begin
          do_clear  = 1'b1;
          pend_next = 1'b0;
        end else if (bus.go) begin
          if (legal) begin
            state_next = ST_DROP;
          end else begin
            done_next   = 1'b1;
            result_next = RES_ILLEGAL;
          end
        end
      end
      ST_DROP:   begin busy = 1'b1; state_next = ST_SCAN_V; end
      ST_SCAN_V: begin busy = 1'b1; state_next = ST_SCAN_H; end
      ST_SCAN_H: begin busy = 1'b1; state_next = ST_SCAN_D; end
      ST_SCAN_D: begin busy = 1'b1; state_next = ST_SCAN_A; end
      ST_SCAN_A: begin
        busy       = 1'b1;
        state_next = ST_REPORT;
        done_next  = 1'b1;
        if (win_reg || step_win)      result_next = RES_WIN;
        else if (moves_reg == CELLS_M) result_next = RES_DRAW;
        else                           result_next = RES_NONE;
        set_over = (result_next != RES_NONE);
      end
      ST_REPORT: begin
        if (bus.new_game || pend_reg) begin
          do_clear  = 1'b1;
          pend_next = 1'b0;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A clear requested mid-move is held until the report cycle.
    if (busy && bus.new_game) pend_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_reg       <= '0;
      row_reg       <= '0;
      owner_reg     <= 1'b0;
      win_reg       <= 1'b0;
      pend_reg      <= 1'b0;
      moves_reg     <= '0;
      game_over_reg <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= RES_NONE;
    end else begin
      done_reg   <= done_next;
      result_reg <= result_next;
      pend_reg   <= pend_next;
      if (accept) begin
        col_reg   <= bus.col;
        row_reg   <= sel_height;
        owner_reg <= bus.player;
        win_reg   <= 1'b0;
      end
      if (scan_step) win_reg <= win_reg | step_win;
      if (do_clear) begin
        moves_reg     <= '0;
        game_over_reg <= 1'b0;
      end else begin
        if (state_reg == ST_DROP) moves_reg <= moves_reg + MW'(1);
        if (set_over)             game_over_reg <= 1'b1;
      end
    end
  end

  assign bus.rd_onoff     = rd_ok ? occ_col[bus.rd_col] : '0;
  assign bus.rd_player    = rd_ok ? (own_col[bus.rd_col] & occ_col[bus.rd_col]) : '0;
  assign bus.busy         = busy;
  assign bus.done         = done_reg;
  assign bus.logic_result = result_reg;
  assign bus.game_over    = game_over_reg;
endmodule

// File: tb/tb_board_logic.sv
// Randomised and directed bench for board_logic against a plain array
// model of the board that finds wins by scanning every possible line.
module tb_board_logic;
  localparam int COLS    = 7;
  localparam int ROWS    = 6;
  localparam int WIN_LEN = 4;
  localparam int CW      = $clog2(COLS);

  logic clk   = 1'b0;
  logic reset = 1'b0;

  board_logic_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  board_logic #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_own [COLS][ROWS];
  int m_h   [COLS];
  int m_moves;
  bit m_over;

  int dcol [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
  int dpl  [10] = '{0, 1, 0, 1, 1, 0, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < COLS; c++) begin
      m_h[c] = 0;
      for (int r = 0; r < ROWS; r++) m_own[c][r] = -1;
    end
    m_moves = 0;
    m_over  = 1'b0;
  endfunction

  // Any WIN_LEN window anywhere on the board fully owned by p.
  function automatic bit has_line(int p);
    int dxs [4] = '{1, 0, 1, 1};
    int dys [4] = '{0, 1, 1, -1};
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1'b1;
          for (int i = 0; i < WIN_LEN; i++) begin
            int x = c + i * dxs[d];
            int y = r + i * dys[d];
            if (x < 0 || x >= COLS || y < 0 || y >= ROWS) ok = 1'b0;
            else if (m_own[x][y] != p)                     ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic check_board();
    for (int c = 0; c <= COLS && c < (1 << CW); c++) begin
      logic [ROWS-1:0] eo, ep;
      eo = '0;
      ep = '0;
      if (c < COLS)
        for (int r = 0; r < ROWS; r++)
          if (m_own[c][r] >= 0) begin
            eo[r] = 1'b1;
            if (m_own[c][r] == 1) ep[r] = 1'b1;
          end
      bus.rd_col = CW'(c);
      #1;
      check("rd_onoff", 32'(bus.rd_onoff), 32'(eo));
      check("rd_player", 32'(bus.rd_player), 32'(ep));
    end
  endtask

  // mode: 0 plain, 1 new_game with go, 2 new_game mid-move,
  //       3 second go during scan, 4 reset during scan
  task automatic do_move(input int c, input int p, input int mode_in);
    int  mode = mode_in;
    bit  legal;
    int  exp_res = 0, exp_lat = 0, exp_busy = 0;
    int  done_cnt = 0, done_at = 0, res_at = 0, busy_cnt = 0;

    legal = (c < COLS) && !m_over;
    if (legal) legal = (m_h[c] < ROWS);
    if ((mode == 2 || mode == 3) && !legal) mode = 0;

    if (mode == 1 || mode == 4) begin
      model_clear();
    end else if (legal) begin
      m_own[c][m_h[c]] = p;
      m_h[c]++;
      m_moves++;
      exp_res  = has_line(p) ? 1 : ((m_moves == COLS * ROWS) ? 2 : 0);
      if (exp_res != 0) m_over = 1'b1;
      exp_lat  = 6;
      exp_busy = 5;
    end else begin
      exp_res  = 3;
      exp_lat  = 1;
      exp_busy = 0;
    end

    @(negedge clk);
    bus.go       = 1'b1;
    bus.col      = CW'(c);
    bus.player   = p[0];
    bus.new_game = (mode == 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = k;
          res_at  = int'(bus.logic_result);
        end
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (k == 1) begin
        bus.go       = 1'b0;
        bus.new_game = 1'b0;
      end
      if (mode == 2) bus.new_game = (k == 3);
      if (mode == 3) begin
        bus.go     = (k == 3);
        bus.col    = CW'((c + 1) % COLS);
        bus.player = ~p[0];
      end
      if (mode == 4 && k == 3) reset = 1'b0;
      if (mode == 4 && k == 5) reset = 1'b1;
    end
    bus.go = 1'b0;
    if (mode == 2) model_clear();

    $display("move col=%0d player=%0d mode=%0d legal=%0d exp_res=%0d done_at=%0d res=%0d",
             c, p, mode, legal, exp_res, done_at, res_at);

    if (mode == 1 || mode == 4) begin
      check("no_done", 32'(done_cnt), 32'd0);
      check("busy_after", 32'(bus.busy), 32'd0);
      check("result_after", 32'(bus.logic_result), 32'd0);
    end else begin
      check("done_count", 32'(done_cnt), 32'd1);
      check("latency", 32'(done_at), 32'(exp_lat));
      check("result", 32'(res_at), 32'(exp_res));
      check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    end
    check("game_over", 32'(bus.game_over), 32'(m_over));
    check_board();
  endtask

  task automatic new_game_t();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    model_clear();
    $display("new_game");
    check("ng_game_over", 32'(bus.game_over), 32'd0);
    check_board();
  endtask

  initial begin
    bus.go       = 1'b0;
    bus.col      = '0;
    bus.player   = 1'b0;
    bus.new_game = 1'b0;
    bus.rd_col   = '0;
    model_clear();

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.logic_result), 32'd0);
    check("rst_game_over", 32'(bus.game_over), 32'd0);
    check_board();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    repeat (4) do_move(3, 0, 0);

    new_game_t();
    for (int c = 0; c < 4; c++) do_move(c, 1, 0);
    do_move(4, 1, 0);

    new_game_t();
    for (int i = 0; i < 10; i++) do_move(dcol[i], dpl[i], 0);

    new_game_t();
    for (int i = 0; i < 7; i++) do_move(5, i % 2, 0);
    do_move(7, 0, 0);

    new_game_t();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) do_move(c, ((r / 2) + c) % 2, 0);
    do_move(0, 0, 0);
    new_game_t();

    do_move(2, 0, 3);
    do_move(4, 1, 4);
    do_move(1, 0, 0);
    do_move(1, 1, 1);
    do_move(6, 1, 2);

    repeat (150) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (m_over && sel < 5)
        new_game_t();
      else
        do_move(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                (sel == 0) ? 2 : ((sel == 1) ? 1 : 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
